multi_channel_transmitter: RTL and testbench
============================================

Name: multi_channel_transmitter

Overview:
- Parametrised successor to the single-word serial data_transmitter.
- Serialises up to CHANNELS words of WIDTH bits per frame. Words are sent in ascending channel order, each prefixed by its channel ID.
- Uses the same three-wire link (transmission, clock, data).
- Sits between counters/sensors and the board pins. A generator pulse (e.g. every_second) triggers it, replacing the free-running single-counter link.

Parameters:
- CHANNELS, 4: number of input words (1..16).
- WIDTH, 64: bits per word (>=1).
- ID_BITS, 2: channel ID prefix width. Must satisfy 2^ID_BITS >= CHANNELS and ID_BITS >= 1.
- CLK_DIV, 4: clk cycles per half period of the serial clock (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- trigger  input  1  frame request, sampled each clk edge; a level held high is a new request every cycle.
- data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- ch_enable  input  CHANNELS  per-channel include mask.
- busy  output  1  high from the accepting edge until the DONE cycle completes.
- transmission  output  1  frame-active strobe.
- clock  output  1  serial clock; idles low.
- out_data  output  1  serial data, MSB first.
- frame_count  output  16  completed frames; wraps 0xFFFF->0.
- overrun  output  1  sticky; set when a trigger arrives while busy.

Behaviour:
- Reset (async, immediate, including mid-frame):
  - busy=0, transmission=0, clock=0, out_data=0, frame_count=0, overrun=0, state=IDLE.
  - A partial frame is abandoned; no completion is counted.
- States: IDLE, LOAD, SHIFT, DONE.

IDLE:
- On an edge with trigger=1 and ch_enable!=0: latch data and ch_enable into internal registers; busy=1; go to LOAD.
- On trigger=1 with ch_enable==0: ignore the request. No state change, no overrun, no count.
- Input changes after latching never affect the frame in progress.

LOAD (1 cycle):
- Select the lowest pending enabled channel c.
- Load the shift register with {c[ID_BITS-1:0], word_c}, ID_BITS+WIDTH bits total; clear that channel's pending bit; go to SHIFT.
- On the edge entering SHIFT: transmission=1, out_data=MSB, clock=0.

SHIFT:
- A half-period counter runs 0..CLK_DIV-1; clock toggles when the counter wraps.
- Each bit: CLK_DIV cycles low, then CLK_DIV cycles high (bit period 2*CLK_DIV).
- out_data changes only on the clock high->low transition. The receiver samples on the rising edge.
- After the high half of the last bit: clock=0.
  - If pending bits remain, go to LOAD. transmission stays 1 and out_data holds its last bit during the LOAD cycle.
  - Otherwise go to DONE.

DONE (1 cycle):
- transmission=0, out_data=0, frame_count increments; next state IDLE with busy=0.

Timing:
- Trigger at edge k: busy=1 from k. First bit appears at edge k+1 (LOAD->SHIFT).
- Total cycles from k to busy falling = N*(1 + (ID_BITS+WIDTH)*2*CLK_DIV) + 1, where N = number of enabled channels.

Overrun:
- Any edge with trigger=1 while busy=1 (LOAD/SHIFT/DONE) sets overrun. The request is dropped.
- overrun is cleared only by reset.

Simultaneous events:
- Trigger in the DONE cycle counts as overrun and is not queued.
- The frame_count increment and overrun setting are independent and may occur on the same edge.

Test Plan:
- CHANNELS=2, WIDTH=8, ID_BITS=1, CLK_DIV=2; data={8'hA5, 8'h3C}, ch_enable=2'b11, trigger pulse -> serial stream 0_00111100 then 1_10100101.
  - transmission high 73 cycles; busy high 75 cycles; frame_count=1.
- Same configuration with ch_enable=2'b10 -> only 1_10100101 sent; busy high 38 cycles.
- ch_enable=0 with trigger -> no activity, busy stays 0, overrun=0, frame_count=0.
- Trigger re-pulsed mid-frame and again in the DONE cycle -> overrun=1; exactly one frame sent; frame_count=1.
- Assert rst during bit 5 of channel 1 -> all outputs 0 immediately; a subsequent trigger sends a full clean frame.
- Force frame_count=0xFFFF via 65536 back-to-back frames (or a hierarchical preset) -> next frame wraps it to 0.
- Change data mid-frame -> transmitted words equal the values latched at the trigger edge.

Source files
------------

// File: rtl/multi_channel_transmitter.sv
// rtl/multi_channel_transmitter.sv - frame serialiser: per-channel ID+word over a transmission/clock/data link
module multi_channel_transmitter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 64,
  parameter int ID_BITS  = 2,
  parameter int CLK_DIV  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trigger,
  input  logic [CHANNELS*WIDTH-1:0]   data,
  input  logic [CHANNELS-1:0]         ch_enable,
  output logic                        busy,
  output logic                        transmission,
  output logic                        clock,
  output logic                        out_data,
  output logic [15:0]                 frame_count,
  output logic                        overrun
);

  localparam int L     = ID_BITS + WIDTH;
  localparam int BIT_W = $clog2(L);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                      state;
  logic [CHANNELS*WIDTH-1:0]   data_q;
  logic [CHANNELS-1:0]         pending;
  logic [L-1:0]                shreg;
  logic [BIT_W-1:0]            bit_cnt;
  logic [DIV_W-1:0]            div_cnt;

  logic [ID_BITS-1:0]          sel_id;
  logic [WIDTH-1:0]            sel_word;
  logic [CHANNELS-1:0]         sel_mask;

  // Descending scan so the lowest pending channel is the one left selected.
  always_comb begin
    sel_id   = '0;
    sel_word = '0;
    sel_mask = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_id   = ID_BITS'(i);
        sel_word = data_q[i*WIDTH +: WIDTH];
        sel_mask = CHANNELS'(1) << i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      data_q       <= '0;
      pending      <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      busy         <= 1'b0;
      transmission <= 1'b0;
      clock        <= 1'b0;
      out_data     <= 1'b0;
      frame_count  <= '0;
      overrun      <= 1'b0;
    end else begin
      if (trigger && busy)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (trigger && (ch_enable != '0)) begin
            data_q  <= data;
            pending <= ch_enable;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end

        LOAD: begin
          shreg        <= {sel_id, sel_word};
          out_data     <= sel_id[ID_BITS-1];
          pending      <= pending & ~sel_mask;
          transmission <= 1'b1;
          clock        <= 1'b0;
          div_cnt      <= '0;
          bit_cnt      <= '0;
          state        <= SHIFT;
        end

        SHIFT: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            clock   <= ~clock;
            // Falling serial edge: advance to the next bit or close this word.
            if (clock) begin
              if (bit_cnt == BIT_W'(L - 1)) begin
                if (pending != '0) begin
                  state <= LOAD;
                end else begin
                  state        <= DONE;
                  transmission <= 1'b0;
                  out_data     <= 1'b0;
                end
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                shreg    <= shreg << 1;
                out_data <= shreg[L-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DONE: begin
          busy        <= 1'b0;
          frame_count <= frame_count + 16'd1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_channel_transmitter.sv
// tb/tb_multi_channel_transmitter.sv - scoreboard bench for multi_channel_transmitter
module tb_multi_channel_transmitter;

  localparam int CH  = 2;
  localparam int W   = 8;
  localparam int IB  = 1;
  localparam int CD  = 2;
  localparam int L   = IB + W;
  localparam int TPC = 1 + L * 2 * CD;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              trigger = 1'b0;
  logic [CH*W-1:0]   data = '0;
  logic [CH-1:0]     ch_enable = '0;
  logic              busy, transmission, clock, out_data, overrun;
  logic [15:0]       frame_count;

  multi_channel_transmitter #(.CHANNELS(CH), .WIDTH(W), .ID_BITS(IB), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .data(data), .ch_enable(ch_enable),
    .busy(busy), .transmission(transmission), .clock(clock), .out_data(out_data),
    .frame_count(frame_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame timing and content from the frame-length formula.
  logic [L-1:0] exp_q[$];
  int           busy_left = 0;
  int           cur_t = 0;
  int           done_frames = 0;
  logic         exp_overrun = 1'b0;
  logic [15:0]  count_base = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_left   = 0;
      cur_t       = 0;
      done_frames = 0;
      exp_overrun = 1'b0;
      exp_q.delete();
    end else if (busy_left > 0) begin
      if (trigger) exp_overrun = 1'b1;
      busy_left--;
      if (busy_left == 0) done_frames++;
    end else if (trigger && ch_enable != '0) begin
      int n;
      n = 0;
      for (int c = 0; c < CH; c++) begin
        if (ch_enable[c]) begin
          exp_q.push_back({IB'(c), data[c*W +: W]});
          n++;
        end
      end
      cur_t     = n * TPC + 1;
      busy_left = cur_t;
    end
  end

  // Monitor: per-cycle status checks and serial capture on rising serial clock.
  logic [L-1:0] rx_bits = '0;
  int           rx_n = 0;
  logic         prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rx_n      = 0;
      prev_sclk = 1'b0;
    end else begin
      logic exp_trans;
      exp_trans = (busy_left > 1) && (busy_left != cur_t);
      check("busy", 32'(busy), 32'(busy_left > 0));
      check("transmission", 32'(transmission), 32'(exp_trans));
      if (!exp_trans) begin
        check("out_data_idle", 32'(out_data), 32'd0);
        check("clock_idle", 32'(clock), 32'd0);
      end
      check("frame_count", 32'(frame_count), 32'(16'(count_base + 16'(done_frames))));
      check("overrun", 32'(overrun), 32'(exp_overrun));
      if (clock && !prev_sclk) begin
        rx_bits = {rx_bits[L-2:0], out_data};
        rx_n++;
        if (rx_n == L) begin
          rx_n = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'(rx_bits), 32'hFFFF_FFFF);
          end else begin
            check("serial_word", 32'(rx_bits), 32'(exp_q.pop_front()));
          end
        end
      end
      prev_sclk = clock;
    end
  end

  task automatic pulse(input logic [CH-1:0] en, input logic [CH*W-1:0] d);
    @(negedge clk);
    data = d;
    ch_enable = en;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic measure(output int busy_n, output int trans_n);
    busy_n = 0;
    trans_n = 0;
    while (busy && busy_n < 5000) begin
      if (transmission) trans_n++;
      busy_n++;
      if (busy_n == 10) data = $urandom;
      @(negedge clk);
    end
    if (busy_n >= 5000) check("timeout", 32'(busy_n), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) check("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    count_base = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_trans", 32'(transmission), 32'd0);
    check("rst_clock", 32'(clock), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(frame_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bn, tn;
    do_reset();

    pulse(2'b11, {8'hA5, 8'h3C});
    measure(bn, tn);
    check("busy_len_2ch", 32'(bn), 32'd75);
    check("trans_len_2ch", 32'(tn), 32'd73);
    @(negedge clk);
    check("count_after_1", 32'(frame_count), 32'd1);

    pulse(2'b10, {8'hA5, 8'h3C});
    measure(bn, tn);
    check("busy_len_1ch", 32'(bn), 32'd38);

    pulse(2'b00, 16'h1234);
    repeat (5) @(negedge clk);
    check("en0_busy", 32'(busy), 32'd0);
    check("en0_overrun", 32'(overrun), 32'd0);
    check("en0_count", 32'(frame_count), 32'd2);

    pulse(2'b11, 16'h5AC3);
    repeat (20) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (75 - 22) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    check("ovr_sticky_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_count", 32'(frame_count), 32'd3);

    pulse(2'b11, 16'hF00F);
    repeat (37 + 1 + 5 * 4 + 1) @(negedge clk);
    do_reset();
    pulse(2'b11, 16'h9669);
    measure(bn, tn);
    check("post_rst_busy_len", 32'(bn), 32'd75);
    @(negedge clk);
    check("post_rst_count", 32'(frame_count), 32'd1);

    for (int it = 0; it < 10; it++) begin
      pulse(2'($urandom), 16'($urandom));
      for (int c = 0; c < int'($urandom_range(90, 0)); c++) begin
        @(negedge clk);
        data = 16'($urandom);
        ch_enable = 2'($urandom);
        trigger = ($urandom_range(15, 0) == 0);
      end
      @(negedge clk);
      trigger = 1'b0;
      wait_idle();
      @(negedge clk);
    end

    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    count_base = 16'hFFFF - 16'(done_frames);
    @(negedge clk);
    release dut.frame_count;
    pulse(2'b01, 16'h00C7);
    measure(bn, tn);
    @(negedge clk);
    check("count_wrap", 32'(frame_count), 32'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    check("partial_bits", 32'(rx_n), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
